// File: rtl/carpark_pkg.sv
// carpark_pkg: gate-state encoding, default parameters and timer sizing for the car-park gate controller
package carpark_pkg;
    typedef enum logic [1:0] {
        G_IDLE    = 2'd0,
        G_OPENING = 2'd1,
        G_OPEN    = 2'd2,
        G_CLOSING = 2'd3
    } gate_state_t;
    localparam int CAPACITY_DEF     = 16;
    localparam int CNT_W_DEF        = 8;
    localparam int OPEN_TIMEOUT_DEF = 1000;
    localparam int ACK_TIMEOUT_DEF  = 100;
    function automatic int timer_w(input int a, input int b);
        int m;
        m = a > b ? a : b;
        return m > 1 ? $clog2(m) : 1;
    endfunction
endpackage

// File: rtl/carpark_occupancy_counter.sv
// carpark_occupancy_counter: saturating occupancy counter with full/empty compares and sticky range error
module carpark_occupancy_counter
    import carpark_pkg::*;
#(
    parameter int CAPACITY = CAPACITY_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enter,
    input  logic             exit,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             range_err
);
    localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);
    assign full  = count == CAP;
    assign empty = count == '0;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count     <= '0;
            range_err <= 1'b0;
        end else if (enter && !exit) begin
            if (full) range_err <= 1'b1;
            else count <= count + 1'b1;
        end else if (exit && !enter) begin
            if (empty) range_err <= 1'b1;
            else count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/carpark_gate_ctrl.sv
// carpark_gate_ctrl: entry-barrier FSM with occupancy tracking; CARPARK_RESERVE_EN adds permit input and RESERVED spaces
module carpark_gate_ctrl
    import carpark_pkg::*;
#(
    parameter int CAPACITY     = CAPACITY_DEF,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int OPEN_TIMEOUT = OPEN_TIMEOUT_DEF,
    parameter int ACK_TIMEOUT  = ACK_TIMEOUT_DEF
`ifdef CARPARK_RESERVE_EN
    ,
    parameter int RESERVED     = 2
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ticket_req,
    input  logic             enter,
    input  logic             exit,
    input  logic             gate_ack,
`ifdef CARPARK_RESERVE_EN
    input  logic             permit,
`endif
    output logic             gate_open,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             reject,
    output logic             fault
);
    localparam int TW = timer_w(OPEN_TIMEOUT, ACK_TIMEOUT);
    localparam logic [TW-1:0] OPEN_LAST = TW'(OPEN_TIMEOUT - 1);
    localparam logic [TW-1:0] ACK_LAST  = TW'(ACK_TIMEOUT - 1);

    gate_state_t   state;
    logic [TW-1:0] timer;
    logic          refuse;
    logic          range_err;
    logic          gate_fault;

`ifdef CARPARK_RESERVE_EN
    assign refuse = permit ? full : count >= CNT_W'(CAPACITY - RESERVED);
`else
    assign refuse = full;
`endif
    assign fault = gate_fault | range_err;

    carpark_occupancy_counter #(.CAPACITY(CAPACITY), .CNT_W(CNT_W)) u_occ (
        .clk       (clk),
        .reset_n   (reset_n),
        .enter     (enter),
        .exit      (exit),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .range_err (range_err)
    );

    // Every transition clears the timer; staying in a non-idle state advances it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= G_IDLE;
            timer      <= '0;
            gate_open  <= 1'b0;
            reject     <= 1'b0;
            gate_fault <= 1'b0;
        end else begin
            reject <= 1'b0;
            timer  <= timer + 1'b1;
            case (state)
                G_IDLE: begin
                    timer <= '0;
                    if (ticket_req && refuse) reject <= 1'b1;
                    else if (ticket_req) begin
                        state     <= G_OPENING;
                        gate_open <= 1'b1;
                    end
                end
                G_OPENING: begin
                    if (gate_ack) begin
                        state <= G_OPEN;
                        timer <= '0;
                    end else if (timer == ACK_LAST) begin
                        state      <= G_CLOSING;
                        gate_open  <= 1'b0;
                        gate_fault <= 1'b1;
                        timer      <= '0;
                    end
                end
                G_OPEN: begin
                    if (enter || timer == OPEN_LAST) begin
                        state     <= G_CLOSING;
                        gate_open <= 1'b0;
                        timer     <= '0;
                    end
                end
                G_CLOSING: begin
                    if (!gate_ack || timer == ACK_LAST) begin
                        state <= G_IDLE;
                        timer <= '0;
                        if (gate_ack) gate_fault <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_carpark_gate_ctrl.sv
// tb_carpark_gate_ctrl: scoreboard bench with a behavioural occupancy/gate model and randomized traffic
module tb_carpark_gate_ctrl;
    localparam int CAP     = 4;
    localparam int CW      = 8;
    localparam int OPEN_TO = 20;
    localparam int ACK_TO  = 8;
`ifdef CARPARK_RESERVE_EN
    localparam int RES = 2;
    logic permit = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ticket_req = 1'b0;
    logic          enter = 1'b0;
    logic          exit = 1'b0;
    logic          gate_ack = 1'b0;
    logic          gate_open, full, empty, reject, fault;
    logic [CW-1:0] count;

    carpark_gate_ctrl #(
        .CAPACITY     (CAP),
        .CNT_W        (CW),
        .OPEN_TIMEOUT (OPEN_TO),
        .ACK_TIMEOUT  (ACK_TO)
`ifdef CARPARK_RESERVE_EN
        ,
        .RESERVED     (RES)
`endif
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ticket_req (ticket_req),
        .enter      (enter),
        .exit       (exit),
        .gate_ack   (gate_ack),
`ifdef CARPARK_RESERVE_EN
        .permit     (permit),
`endif
        .gate_open  (gate_open),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .reject     (reject),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit g;
        int c;
        bit f;
        bit e;
        bit r;
        bit x;
    } exp_t;

    exp_t  q[$];
    exp_t  e_m;
    int    n_chk = 0;
    int    n_fail = 0;
    event  chk_ev;

    int    occ = 0;
    int    age = 0;
    string ph = "idle";
    bit    m_gate = 0;
    bit    m_rej = 0;
    bit    m_flt = 0;
    bit    stuck = 0;
    int    lat = 2;
    int    lag = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always begin
        @(posedge clk or chk_ev);
        #2;
        if (q.size() > 0) begin
            e_m = q.pop_front();
            chk("gate_open", int'(gate_open), int'(e_m.g));
            chk("count", int'(count), e_m.c);
            chk("full", int'(full), int'(e_m.f));
            chk("empty", int'(empty), int'(e_m.e));
            chk("reject", int'(reject), int'(e_m.r));
            chk("fault", int'(fault), int'(e_m.x));
        end
    end

    function automatic void model_reset();
        occ = 0;
        age = 0;
        ph = "idle";
        m_gate = 0;
        m_rej = 0;
        m_flt = 0;
    endfunction

    // One clock edge of the car park as described by its rules: phase, time spent in it, occupancy.
    function automatic void model_edge(input bit tr, input bit en, input bit ex, input bit ack, input bit pm);
        bit    refuse;
        string nph;
        refuse = occ >= CAP;
`ifdef CARPARK_RESERVE_EN
        if (!pm) refuse = occ >= CAP - RES;
`endif
        m_rej = 0;
        nph = ph;
        if (ph == "idle") begin
            if (tr && refuse) m_rej = 1;
            else if (tr) nph = "opening";
        end else if (ph == "opening") begin
            if (ack) nph = "open";
            else if (age + 1 == ACK_TO) begin m_flt = 1; nph = "closing"; end
        end else if (ph == "open") begin
            if (en || age + 1 == OPEN_TO) nph = "closing";
        end else begin
            if (!ack) nph = "idle";
            else if (age + 1 == ACK_TO) begin m_flt = 1; nph = "idle"; end
        end
        age = (nph == ph && ph != "idle") ? age + 1 : 0;
        ph = nph;
        m_gate = (ph == "opening" || ph == "open");
        if (en && !ex) begin
            if (occ == CAP) m_flt = 1;
            else occ++;
        end else if (ex && !en) begin
            if (occ == 0) m_flt = 1;
            else occ--;
        end
    endfunction

    function automatic void push();
        q.push_back('{m_gate, occ, occ == CAP, occ == 0, m_rej, m_flt});
    endfunction

    task automatic cyc(input bit tr, input bit en, input bit ex, input bit pm);
        ticket_req = tr;
        enter = en;
        exit = ex;
`ifdef CARPARK_RESERVE_EN
        permit = pm;
`endif
        if (!stuck && gate_ack != m_gate) begin
            if (lag >= lat) begin
                gate_ack = m_gate;
                lag = 0;
            end else lag++;
        end
        if (!reset_n) model_reset();
        else model_edge(tr, en, ex, gate_ack, pm);
        push();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0);
    endtask

    task automatic wait_ph(input string p);
        int k = 0;
        while (ph != p && k < 60) begin
            cyc(0, 0, 0, 0);
            k++;
        end
    endtask

    task automatic park_one(input bit pm);
        cyc(1, 0, 0, pm);
        wait_ph("open");
        cyc(0, 1, 0, 0);
        wait_ph("idle");
    endtask

    initial begin
        idle(3);
        reset_n = 1'b1;
        lat = 3;
        park_one(0);
        cyc(0, 0, 1, 0);
        lat = 1;
        repeat (4) park_one(0);
        cyc(1, 0, 0, 0);
        idle(3);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 1, 1, 0);
        idle(1);
        cyc(1, 0, 0, 1);
        wait_ph("open");
        idle(OPEN_TO + 2);
        wait_ph("idle");
`ifdef CARPARK_RESERVE_EN
        cyc(1, 0, 0, 0);
        idle(2);
`endif
        park_one(1);
        cyc(1, 0, 0, 1);
        wait_ph("open");
        idle(2);
        #1;
        reset_n = 1'b0;
        model_reset();
        push();
        ->chk_ev;
        #3;
        idle(2);
        reset_n = 1'b1;
        idle(3);
        cyc(0, 0, 1, 0);
        idle(2);
        stuck = 1;
        gate_ack = 1'b0;
        cyc(1, 0, 0, 1);
        idle(ACK_TO + 4);
        stuck = 0;
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        repeat (400) begin
            lat = $urandom_range(0, 3);
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)));
        end
        idle(2);
        @(posedge clk);
        #5;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
